l2_xip_arbiter: RTL and testbench

Round-robin arbiter that shares the single blocking XIP (execute-in-place) port of the L2 interconnect among `N_MASTERS` requesters. It sits between the per-master XIP outputs of the L2 address demultiplexers and the XIP controller. It enforces one outstanding transaction and routes each response back to its owner. An optional watchdog returns an error response if the XIP controller never answers.

---
 rtl/l2_xip_arbiter_if.sv | 50 +++++
 rtl/l2_xip_arbiter.sv | 168 ++++++++++++++++
 tb/tb_l2_xip_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_xip_arbiter_if.sv
// Request/response bundle between the XIP masters, the arbiter and the XIP controller.
// slave: arbiter view (m_* in, xip_* out); master: environment view.
interface l2_xip_arbiter_if #(
  parameter int N_MASTERS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int AUX_WIDTH  = 4
);
  logic [N_MASTERS-1:0]  m_req_i;
  logic [ADDR_WIDTH-1:0] m_add_i   [N_MASTERS];
  logic                  m_wen_i   [N_MASTERS];
  logic [DATA_WIDTH-1:0] m_wdata_i [N_MASTERS];
  logic [BE_WIDTH-1:0]   m_be_i    [N_MASTERS];
  logic [AUX_WIDTH-1:0]  m_aux_i   [N_MASTERS];
  logic [N_MASTERS-1:0]  m_gnt_o;
  logic [N_MASTERS-1:0]  m_r_valid_o;
  logic [DATA_WIDTH-1:0] m_r_rdata_o;
  logic                  m_r_opc_o;
  logic [AUX_WIDTH-1:0]  m_r_aux_o;
  logic                  xip_req_o;
  logic [ADDR_WIDTH-1:0] xip_add_o;
  logic                  xip_wen_o;
  logic [DATA_WIDTH-1:0] xip_wdata_o;
  logic [BE_WIDTH-1:0]   xip_be_o;
  logic [AUX_WIDTH-1:0]  xip_aux_o;
  logic                  xip_gnt_i;
  logic                  xip_r_valid_i;
  logic [DATA_WIDTH-1:0] xip_r_rdata_i;
  logic                  xip_r_opc_i;
  logic [AUX_WIDTH-1:0]  xip_r_aux_i;

  modport slave (
    input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, m_aux_i,
    input  xip_gnt_i, xip_r_valid_i, xip_r_rdata_i, xip_r_opc_i,
    input  xip_r_aux_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_aux_o,
    output xip_req_o, xip_add_o, xip_wen_o, xip_wdata_o, xip_be_o,
    output xip_aux_o
  );

  modport master (
    output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, m_aux_i,
    output xip_gnt_i, xip_r_valid_i, xip_r_rdata_i, xip_r_opc_i,
    output xip_r_aux_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_aux_o,
    input  xip_req_o, xip_add_o, xip_wen_o, xip_wdata_o, xip_be_o,
    input  xip_aux_o
  );
endinterface

// File: rtl/l2_xip_arbiter.sv
// Round-robin arbiter sharing one blocking XIP port, one transaction in flight.
// Ports: clk, rst (sync, active-high), bus (slave modport), busy_o, owner_o.
// Optional watchdog error response: define XIP_ARB_TIMEOUT_EN.
module l2_xip_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int AUX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  l2_xip_arbiter_if.slave              bus,
  output logic                         busy_o,
  output logic [$clog2(N_MASTERS)-1:0] owner_o
);
  localparam int OW = $clog2(N_MASTERS);
  localparam logic [OW:0] NM = (OW+1)'(N_MASTERS);

`ifdef XIP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [2:0] {IDLE, LOCK, WAIT_RSP, TO_ERR, DRAIN} state_e;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AUX_WIDTH-1:0] aux_q, aux_d;
`else
  typedef enum logic [1:0] {IDLE, LOCK, WAIT_RSP} state_e;
`endif

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic          found;
  logic [OW-1:0] win;
  logic [OW:0]   cand;
  logic [OW-1:0] sel;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
    return (x == OW'(N_MASTERS-1)) ? '0 : x + OW'(1);
  endfunction

  // first requester at or above rr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = {1'b0, rr_q} + (OW+1)'(i);
      if (cand >= NM) cand = cand - NM;
      if (!found && bus.m_req_i[cand[OW-1:0]]) begin
        found = 1'b1;
        win   = cand[OW-1:0];
      end
    end
  end

  // LOCK keeps the latched owner; no re-arbitration until granted
  assign sel = (state_q == LOCK) ? owner_q : win;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
`ifdef XIP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    aux_d   = aux_q;
`endif
    bus.m_gnt_o     = '0;
    bus.m_r_valid_o = '0;
    bus.m_r_rdata_o = '0;
    bus.m_r_opc_o   = 1'b0;
    bus.m_r_aux_o   = '0;
    bus.xip_req_o   = 1'b0;
    bus.xip_add_o   = '0;
    bus.xip_wen_o   = 1'b0;
    bus.xip_wdata_o = '0;
    bus.xip_be_o    = '0;
    bus.xip_aux_o   = '0;
    unique case (state_q)
      IDLE, LOCK: begin
        if (state_q == LOCK || found) begin
          bus.xip_req_o    = 1'b1;
          bus.xip_add_o    = bus.m_add_i[sel];
          bus.xip_wen_o    = bus.m_wen_i[sel];
          bus.xip_wdata_o  = bus.m_wdata_i[sel];
          bus.xip_be_o     = bus.m_be_i[sel];
          bus.xip_aux_o    = bus.m_aux_i[sel];
          bus.m_gnt_o[sel] = bus.xip_gnt_i;
          owner_d          = sel;
          if (bus.xip_gnt_i) begin
            state_d = WAIT_RSP;
            rr_d    = wrap_inc(sel);
`ifdef XIP_ARB_TIMEOUT_EN
            aux_d   = bus.m_aux_i[sel];
            cnt_d   = '0;
`endif
          end else begin
            state_d = LOCK;
          end
        end
      end
      WAIT_RSP: begin
        bus.m_r_valid_o[owner_q] = bus.xip_r_valid_i;
        bus.m_r_rdata_o = bus.xip_r_rdata_i;
        bus.m_r_opc_o   = bus.xip_r_opc_i;
        bus.m_r_aux_o   = bus.xip_r_aux_i;
        if (bus.xip_r_valid_i) state_d = IDLE;
`ifdef XIP_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYCLES-1)) state_d = TO_ERR;
        end
`endif
      end
`ifdef XIP_ARB_TIMEOUT_EN
      TO_ERR: begin
        bus.m_r_valid_o[owner_q] = 1'b1;
        bus.m_r_rdata_o = DATA_WIDTH'(32'hBADACCE5);
        bus.m_r_opc_o   = 1'b1;
        bus.m_r_aux_o   = aux_q;
        state_d         = DRAIN;
      end
      DRAIN: begin
        // the late response is swallowed
        if (bus.xip_r_valid_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // reset is synchronous, so the outputs are forced quiet explicitly
    if (rst) begin
      bus.m_gnt_o     = '0;
      bus.m_r_valid_o = '0;
      bus.m_r_rdata_o = '0;
      bus.m_r_opc_o   = 1'b0;
      bus.m_r_aux_o   = '0;
      bus.xip_req_o   = 1'b0;
      bus.xip_add_o   = '0;
      bus.xip_wen_o   = 1'b0;
      bus.xip_wdata_o = '0;
      bus.xip_be_o    = '0;
      bus.xip_aux_o   = '0;
    end
  end

  assign busy_o  = !rst && (state_q != IDLE);
  assign owner_o = rst ? '0 : owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
`ifdef XIP_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      aux_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
`ifdef XIP_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      aux_q   <= aux_d;
`endif
    end
  end
endmodule

// File: tb/tb_l2_xip_arbiter.sv
// Bench for l2_xip_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_l2_xip_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int XW = 4;
  localparam int T  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] owner;
  int total = 0;
  int bad   = 0;

  l2_xip_arbiter_if #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BE_WIDTH(BW), .AUX_WIDTH(XW)
  ) bus ();

  l2_xip_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BE_WIDTH(BW), .AUX_WIDTH(XW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  // model: who is locked, who owes a response, where rr points
  int rr_m = 0;
  int lock_m = -1;
  int pend_m = -1;
  int own_m = 0;
  int wd_m = 0;
  bit err_m = 0;
  bit drain_m = 0;
  logic [XW-1:0] aux_m = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0]  eg, ev;
    logic          ereq, ewen, eopc;
    logic [AW-1:0] eadd;
    logic [DW-1:0] ewd, erd;
    logic [BW-1:0] ebe;
    logic [XW-1:0] exa, era;
    int cand, ng;
    eg = '0; ev = '0; ereq = 0; ewen = 0; eopc = 0;
    eadd = '0; ewd = '0; erd = '0; ebe = '0; exa = '0; era = '0;
    cand = -1; ng = -1;
    if (rst) begin
      cand = -1;
    end else if (pend_m < 0 && !err_m && !drain_m) begin
      if (lock_m >= 0) cand = lock_m;
      else
        for (int k = 0; k < N; k++)
          if (cand < 0 && bus.m_req_i[(rr_m + k) % N]) cand = (rr_m + k) % N;
      if (cand >= 0) begin
        ereq = 1;
        eadd = bus.m_add_i[cand];
        ewen = bus.m_wen_i[cand];
        ewd  = bus.m_wdata_i[cand];
        ebe  = bus.m_be_i[cand];
        exa  = bus.m_aux_i[cand];
        eg[cand] = bus.xip_gnt_i;
      end
    end else if (err_m) begin
      ev[pend_m] = 1; erd = 32'hBADACCE5; eopc = 1; era = aux_m;
    end else if (pend_m >= 0) begin
      ev[pend_m] = bus.xip_r_valid_i;
      erd = bus.xip_r_rdata_i; eopc = bus.xip_r_opc_i; era = bus.xip_r_aux_i;
    end
    chk("gnt", 64'(bus.m_gnt_o), 64'(eg));
    chk("rvalid", 64'(bus.m_r_valid_o), 64'(ev));
    chk("rdata", 64'(bus.m_r_rdata_o), 64'(erd));
    chk("ropc", 64'(bus.m_r_opc_o), 64'(eopc));
    chk("raux", 64'(bus.m_r_aux_o), 64'(era));
    chk("xreq", 64'(bus.xip_req_o), 64'(ereq));
    chk("xadd", 64'(bus.xip_add_o), 64'(eadd));
    chk("xwen", 64'(bus.xip_wen_o), 64'(ewen));
    chk("xwdata", 64'(bus.xip_wdata_o), 64'(ewd));
    chk("xbe", 64'(bus.xip_be_o), 64'(ebe));
    chk("xaux", 64'(bus.xip_aux_o), 64'(exa));
    chk("busy", 64'(busy),
        64'(!rst && (pend_m >= 0 || lock_m >= 0 || err_m || drain_m)));
    chk("owner", 64'(owner), rst ? 64'd0 : 64'(own_m));
    @(posedge clk);
    if (rst) begin
      rr_m = 0; lock_m = -1; pend_m = -1; own_m = 0;
      wd_m = 0; err_m = 0; drain_m = 0; aux_m = '0;
    end else if (cand >= 0) begin
      own_m = cand;
      if (bus.xip_gnt_i) begin
        pend_m = cand; lock_m = -1; rr_m = (cand + 1) % N;
        aux_m = bus.m_aux_i[cand]; wd_m = 0; ng = cand;
      end else lock_m = cand;
    end else if (err_m) begin
      err_m = 0; drain_m = 1; pend_m = -1;
    end else if (drain_m) begin
      if (bus.xip_r_valid_i) drain_m = 0;
    end else if (pend_m >= 0) begin
      if (bus.xip_r_valid_i) pend_m = -1;
      else begin
        wd_m++;
`ifdef XIP_ARB_TIMEOUT_EN
        if (wd_m == T) err_m = 1;
`endif
      end
    end
    #1;
    if (ng >= 0) bus.m_req_i[ng] = 1'b0;
  endtask

  task automatic set_req(int i, logic [AW-1:0] a);
    bus.m_req_i[i]   = 1'b1;
    bus.m_add_i[i]   = a;
    bus.m_wen_i[i]   = 1'($urandom_range(1));
    bus.m_wdata_i[i] = $urandom;
    bus.m_be_i[i]    = 4'($urandom_range(15));
    bus.m_aux_i[i]   = 4'($urandom_range(15));
  endtask

  task automatic xin(logic g, logic v);
    bus.xip_gnt_i     = g;
    bus.xip_r_valid_i = v;
    bus.xip_r_rdata_i = $urandom;
    bus.xip_r_opc_i   = 1'($urandom_range(1));
    bus.xip_r_aux_i   = 4'($urandom_range(15));
  endtask

  task automatic drive_rand();
    for (int i = 0; i < N; i++)
      if (!bus.m_req_i[i] && $urandom_range(2) == 0) set_req(i, $urandom);
    xin(1'($urandom_range(2) != 0), 1'($urandom_range(2) == 0));
    rst = ($urandom_range(199) == 0);
  endtask

  initial begin
    bus.m_req_i = '0;
    for (int i = 0; i < N; i++) begin
      bus.m_add_i[i] = '0; bus.m_wen_i[i] = 1'b0; bus.m_wdata_i[i] = '0;
      bus.m_be_i[i] = '0; bus.m_aux_i[i] = '0;
    end
    xin(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk); #1; step();
    @(negedge clk); set_req(1, 32'h11); #1; step();
    bus.m_req_i = '0;

    // masters 0 and 2 together, rr = 0
    @(negedge clk); rst = 0;
    set_req(0, 32'h100); set_req(2, 32'h300); xin(1, 0);
    #1; chk("d1_first", 64'(bus.m_gnt_o), 64'b0001); step();
    @(negedge clk); xin(1, 1);
    #1; chk("d1_bubble", 64'(bus.m_gnt_o), 64'b0000); step();
    @(negedge clk); xin(1, 0);
    #1; chk("d1_second", 64'(bus.m_gnt_o), 64'b0100); step();
    @(negedge clk); xin(0, 1); #1; step();

    // master 1 locked while xip grant low, master 3 joins
    @(negedge clk); set_req(1, 32'hA1); xin(0, 0); #1; step();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (!bus.m_req_i[3]) set_req(3, 32'hA3);
      xin(0, 0);
      #1; chk("d2_lock_add", 64'(bus.xip_add_o), 64'hA1); step();
    end
    @(negedge clk); xin(1, 0);
    #1; chk("d2_gnt1", 64'(bus.m_gnt_o), 64'b0010); step();
    @(negedge clk); xin(0, 1); #1; step();

    // read from master 3
    @(negedge clk); bus.m_wen_i[3] = 1'b0; xin(1, 0);
    #1; chk("d3_gnt3", 64'(bus.m_gnt_o), 64'b1000); step();
    @(negedge clk); xin(0, 1);
    bus.xip_r_rdata_i = 32'h1234_5678; bus.xip_r_aux_i = 4'hA;
    #1;
    chk("d3_rvalid", 64'(bus.m_r_valid_o), 64'b1000);
    chk("d3_rdata", 64'(bus.m_r_rdata_o), 64'h1234_5678);
    chk("d3_raux", 64'(bus.m_r_aux_o), 64'hA);
    step();
    @(negedge clk); xin(0, 0);
    #1; chk("d3_busy", 64'(busy), 64'd0); step();

`ifdef XIP_ARB_TIMEOUT_EN
    // watchdog expiry then a late response
    @(negedge clk); set_req(0, 32'hB0); xin(1, 0); #1; step();
    for (int c = 0; c < T; c++) begin
      @(negedge clk); xin(0, 0); #1; step();
    end
    @(negedge clk); xin(0, 0);
    #1;
    chk("to_opc", 64'(bus.m_r_opc_o), 64'd1);
    chk("to_rdata", 64'(bus.m_r_rdata_o), 64'hBADACCE5);
    chk("to_valid", 64'(bus.m_r_valid_o), 64'b0001);
    step();
    @(negedge clk); set_req(2, 32'hB2); xin(1, 1);
    #1;
    chk("drain_rv", 64'(bus.m_r_valid_o), 64'd0);
    chk("drain_gnt", 64'(bus.m_gnt_o), 64'd0);
    step();
    @(negedge clk); xin(1, 0);
    #1; chk("drain_next", 64'(bus.m_gnt_o), 64'b0100); step();
    // response on the expiry cycle wins
    for (int c = 0; c < T - 1; c++) begin
      @(negedge clk); xin(0, 0); #1; step();
    end
    @(negedge clk); xin(0, 1); bus.xip_r_opc_i = 1'b0;
    #1;
    chk("race_rv", 64'(bus.m_r_valid_o), 64'b0100);
    chk("race_opc", 64'(bus.m_r_opc_o), 64'd0);
    step();
    @(negedge clk); xin(0, 0);
    #1; chk("race_idle", 64'(busy), 64'd0); step();
`endif

    // reset in WAIT_RSP, then a stray response
    @(negedge clk); set_req(0, 32'hC0); xin(1, 0); #1; step();
    @(negedge clk); rst = 1; xin(1, 0);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_xreq", 64'(bus.xip_req_o), 64'd0);
    step();
    @(negedge clk); rst = 0; bus.m_req_i = '0; xin(0, 1);
    #1; chk("rst_stray", 64'(bus.m_r_valid_o), 64'd0); step();

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); drive_rand(); #1; step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
